// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures the period and high time of a slow square wave that is
// asynchronous to the system clock. Both are counted in clk cycles between
// successive rising edges. The block also recovers the power-of-two divide
// exponent that would have produced the wave.
//
// Parameters
//   SYNC_STAGES     synchronizer depth for sig_in (>= 2)
//   TIMEOUT_CYCLES  cycles without a rising edge before loss of signal
//                   (4 .. 2^32-1)
//
// Ports
//   clk        in   system clock, the only clock
//   resetn     in   asynchronous active-low reset
//   sig_in     in   measured signal, asynchronous to clk
//   period     out  clk cycles between the last two rising edges
//   high_time  out  clk cycles sig_in was high within that period
//   n_est      out  max(msb_index(period) - 1, 0)
//   pow2       out  period is an exact power of two
//   valid      out  one-cycle pulse when the measurement outputs update
//   locked     out  a measurement completed since reset or timeout
//   timeout    out  sticky loss-of-signal flag
// -----------------------------------------------------------------------------
module clk_period_meter #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sig_in,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic [4:0]  n_est,
  output logic        pow2,
  output logic        valid,
  output logic        locked,
  output logic        timeout
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_ARM       = 2'd0,
    S_WAIT_EDGE = 2'd1,
    S_MEASURE   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Divide exponent: max(msb_index(v) - 1, 0). Values below 4 give 0.
  function automatic logic [4:0] f_n_est(input logic [DATA_W-1:0] v);
    logic [4:0] msb;
    msb = 5'd0;
    for (int i = 0; i < DATA_W; i++) begin
      if (v[i]) msb = i[4:0];
    end
    if (msb < 5'd2) return 5'd0;
    return msb - 5'd1;
  endfunction

  // Exact power of two (zero is not a power of two).
  function automatic logic f_pow2(input logic [DATA_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: input synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_sig_d;
  logic                   w_sig_s;
  logic                   w_rise;
  logic                   w_primed;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_sig_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sig_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sig_s = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_sig_s & ~r_sig_d;

  // The zeros loaded into the synchronizer by reset are not an observation of
  // sig_in. ARM only trusts a low sig_s once real samples have reached the end
  // of the chain. Otherwise an input held high through reset release would
  // look like a low level followed by a rising edge.
  assign w_primed = r_fill[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Stage p1: counters, FSM and registered measurement outputs
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [DATA_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_hcnt;
  logic                w_at_limit;

  // A rise in the same cycle as the limit wins, so this is only acted on
  // when there is no rise.
  assign w_at_limit = (r_cnt == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_ARM;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      period    <= '0;
      high_time <= '0;
      n_est     <= '0;
      pow2      <= 1'b0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_ARM: begin
          // The counters are held at zero so WAIT_EDGE starts its timeout
          // count from a cleared cnt.
          r_cnt  <= '0;
          r_hcnt <= '0;
          if (w_primed && !w_sig_s) begin
            r_state <= S_WAIT_EDGE;
          end
        end

        S_WAIT_EDGE: begin
          if (w_rise) begin
            r_cnt   <= 32'd1;
            r_hcnt  <= 32'd1;
            r_state <= S_MEASURE;
          end else if (w_at_limit) begin
            timeout   <= 1'b1;
            locked    <= 1'b0;
            period    <= '0;
            high_time <= '0;
            n_est     <= '0;
            pow2      <= 1'b0;
            r_state   <= S_ARM;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        S_MEASURE: begin
          if (w_rise) begin
            // The rise cycle is counted as the first cycle of the next
            // period, so cnt already holds the full period here.
            period    <= r_cnt;
            high_time <= r_hcnt;
            n_est     <= f_n_est(r_cnt);
            pow2      <= f_pow2(r_cnt);
            valid     <= 1'b1;
            locked    <= 1'b1;
            timeout   <= 1'b0;
            r_cnt     <= 32'd1;
            r_hcnt    <= 32'd1;
          end else if (w_at_limit) begin
            timeout   <= 1'b1;
            locked    <= 1'b0;
            period    <= '0;
            high_time <= '0;
            n_est     <= '0;
            pow2      <= 1'b0;
            r_state   <= S_ARM;
          end else begin
            r_cnt  <= r_cnt + 32'd1;
            r_hcnt <= r_hcnt + {{(DATA_W-1){1'b0}}, w_sig_s};
          end
        end

        default: begin
          r_state <= S_ARM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
module tb_clk_period_meter;

  localparam int TO = 1000;

  logic        clk;
  logic        resetn;
  logic        sig_in;
  logic [31:0] period;
  logic [31:0] high_time;
  logic [4:0]  n_est;
  logic        pow2;
  logic        valid;
  logic        locked;
  logic        timeout;

  clk_period_meter #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(32'd1000)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .n_est    (n_est),
    .pow2     (pow2),
    .valid    (valid),
    .locked   (locked),
    .timeout  (timeout)
  );

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] h;
    logic [4:0]  n;
    logic        pw;
    logic        lk;
    logic        to;
  } meas_t;

  int    total = 0;
  int    bad   = 0;
  meas_t mq[$];
  int    cyc = 0;
  int    last_valid_cyc = 0;
  int    dbl_cnt = 0;
  logic  prev_valid = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid pulse with the outputs visible in that cycle.
  always @(negedge clk) begin
    if (valid) begin
      mq.push_back('{period, high_time, n_est, pow2, locked, timeout});
      last_valid_cyc <= cyc;
    end
    if (valid && prev_valid) dbl_cnt <= dbl_cnt + 1;
    prev_valid <= valid;
  end

  // Reference: a wave high for h cycles and low for l cycles has period h+l.
  // n_est comes from floor(log2(period)).
  function automatic meas_t model(int h, int l);
    meas_t m;
    int    p;
    int    lg;
    p  = h + l;
    lg = 0;
    while ((64'd1 << (lg + 1)) <= 64'(p)) lg++;
    m.p  = 32'(p);
    m.h  = 32'(h);
    m.n  = (lg >= 2) ? 5'(lg - 1) : 5'd0;
    m.pw = ((64'd1 << lg) == 64'(p));
    m.lk = 1'b1;
    m.to = 1'b0;
    return m;
  endfunction

  task automatic drive_wave(int h, int l, int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < h; i++) begin @(negedge clk); sig_in = 1'b1; end
      for (int i = 0; i < l; i++) begin @(negedge clk); sig_in = 1'b0; end
    end
  endtask

  task automatic apply_reset(logic lvl);
    @(negedge clk);
    sig_in = lvl;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mq.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    sig_in = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    total++;
    if ({period, high_time, n_est, pow2, valid, locked, timeout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got p=%0d h=%0d n=%0d pw=%0b v=%0b lk=%0b to=%0b want all 0",
               period, high_time, n_est, pow2, valid, locked, timeout);
    end
    resetn = 1'b1;
  endtask

  task automatic test_fixed_patterns();
    int th[3] = '{8, 1, 3};
    int tl[3] = '{8, 1, 7};
    string nm[3] = '{"div8", "toggle", "h3l7"};
    meas_t e;
    for (int t = 0; t < 3; t++) begin
      apply_reset(1'b0);
      repeat (4) @(negedge clk);
      drive_wave(th[t], tl[t], 6);
      repeat (6) @(negedge clk);
      e = model(th[t], tl[t]);
      total++;
      if (mq.size() !== 5) begin
        bad++;
        $display("FAIL %s_count got %0d want 5", nm[t], mq.size());
      end
      foreach (mq[i]) begin
        total++;
        if (mq[i] !== e) begin
          bad++;
          $display("FAIL %s[%0d] got p=%0d h=%0d n=%0d pw=%0b lk=%0b to=%0b want p=%0d h=%0d n=%0d pw=%0b lk=1 to=0",
                   nm[t], i, mq[i].p, mq[i].h, mq[i].n, mq[i].pw, mq[i].lk, mq[i].to,
                   e.p, e.h, e.n, e.pw);
        end
      end
    end
  endtask

  task automatic test_random();
    int    h, l, n;
    meas_t e;
    for (int t = 0; t < 6; t++) begin
      h = $urandom_range(1, 40);
      l = $urandom_range(1, 40);
      n = $urandom_range(3, 6);
      apply_reset(1'b0);
      repeat (4) @(negedge clk);
      drive_wave(h, l, n);
      repeat (6) @(negedge clk);
      e = model(h, l);
      total++;
      if (mq.size() !== n - 1) begin
        bad++;
        $display("FAIL rand%0d_count h=%0d l=%0d got %0d want %0d", t, h, l, mq.size(), n - 1);
      end
      foreach (mq[i]) begin
        total++;
        if (mq[i] !== e) begin
          bad++;
          $display("FAIL rand%0d[%0d] got p=%0d h=%0d n=%0d pw=%0b lk=%0b to=%0b want p=%0d h=%0d n=%0d pw=%0b lk=1 to=0",
                   t, i, mq[i].p, mq[i].h, mq[i].n, mq[i].pw, mq[i].lk, mq[i].to,
                   e.p, e.h, e.n, e.pw);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic  seen;
    int    seen_cyc;
    meas_t e;
    apply_reset(1'b0);
    repeat (4) @(negedge clk);
    drive_wave(8, 8, 4);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL to_prelock got locked=%0b want 1", locked);
    end
    seen = 1'b0;
    seen_cyc = 0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        seen = 1'b1;
        seen_cyc = cyc;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL to_seen got no timeout within 1200 cycles want timeout");
    end else if (seen_cyc - last_valid_cyc !== TO) begin
      bad++;
      $display("FAIL to_latency got %0d cycles want %0d", seen_cyc - last_valid_cyc, TO);
    end
    total++;
    if ({timeout, locked, period, high_time, n_est, pow2} !== {1'b1, 1'b0, 70'd0}) begin
      bad++;
      $display("FAIL to_outputs got to=%0b lk=%0b p=%0d h=%0d n=%0d pw=%0b want to=1 lk=0 rest 0",
               timeout, locked, period, high_time, n_est, pow2);
    end
    mq.delete();
    drive_wave(8, 8, 1);
    total++;
    if (mq.size() !== 0 || timeout !== 1'b1) begin
      bad++;
      $display("FAIL to_first_rise got valids=%0d to=%0b want valids=0 to=1", mq.size(), timeout);
    end
    drive_wave(8, 8, 2);
    repeat (6) @(negedge clk);
    e = model(8, 8);
    total++;
    if (mq.size() !== 2) begin
      bad++;
      $display("FAIL to_relock_count got %0d want 2", mq.size());
    end else if (mq[0] !== e) begin
      bad++;
      $display("FAIL to_relock got p=%0d lk=%0b to=%0b want p=16 lk=1 to=0", mq[0].p, mq[0].lk, mq[0].to);
    end
  endtask

  task automatic test_high_at_reset();
    meas_t e;
    apply_reset(1'b1);
    repeat (20) @(negedge clk);
    total++;
    if (mq.size() !== 0 || locked !== 1'b0) begin
      bad++;
      $display("FAIL hirst_idle got valids=%0d lk=%0b want 0 0", mq.size(), locked);
    end
    for (int i = 0; i < 8; i++) begin @(negedge clk); sig_in = 1'b0; end
    drive_wave(8, 8, 3);
    repeat (6) @(negedge clk);
    e = model(8, 8);
    total++;
    if (mq.size() !== 2) begin
      bad++;
      $display("FAIL hirst_count got %0d want 2", mq.size());
    end else if (mq[0] !== e) begin
      bad++;
      $display("FAIL hirst_first got p=%0d h=%0d want p=16 h=8", mq[0].p, mq[0].h);
    end
  endtask

  task automatic test_mid_reset();
    meas_t e;
    apply_reset(1'b0);
    repeat (4) @(negedge clk);
    drive_wave(8, 8, 3);
    for (int i = 0; i < 4; i++) begin @(negedge clk); sig_in = 1'b1; end
    total++;
    if (locked !== 1'b1 || period !== 32'd16) begin
      bad++;
      $display("FAIL mid_prelock got lk=%0b p=%0d want lk=1 p=16", locked, period);
    end
    resetn = 1'b0;
    #1;
    total++;
    if ({period, high_time, n_est, pow2, valid, locked, timeout} !== '0) begin
      bad++;
      $display("FAIL mid_async_clear got p=%0d h=%0d n=%0d lk=%0b want all 0", period, high_time, n_est, locked);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    mq.delete();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin @(negedge clk); sig_in = 1'b0; end
    drive_wave(8, 8, 3);
    repeat (6) @(negedge clk);
    e = model(8, 8);
    total++;
    if (mq.size() !== 2) begin
      bad++;
      $display("FAIL mid_relock_count got %0d want 2", mq.size());
    end else if (mq[0] !== e) begin
      bad++;
      $display("FAIL mid_relock got p=%0d h=%0d want p=16 h=8", mq[0].p, mq[0].h);
    end
  endtask

  task automatic test_valid_width();
    total++;
    if (dbl_cnt !== 0) begin
      bad++;
      $display("FAIL valid_width got %0d multi-cycle pulses want 0", dbl_cnt);
    end
  endtask

  initial begin
    resetn = 1'b0;
    sig_in = 1'b0;
    test_reset();
    test_fixed_patterns();
    test_random();
    test_timeout();
    test_high_at_reset();
    test_mid_reset();
    test_valid_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, asynchronous square wave (typically a divided clock) in system-clock cycles. It recovers the power-of-two divide exponent that produced the wave. It sits on the receiving side of the lab's divided-clock outputs and feeds display/self-check logic, so the board can verify its own dividers and external clock sources against the 100 MHz system clock.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `sig_in`, minimum 2.
- `TIMEOUT_CYCLES`, default 100_000_000: cycles without a rising edge before the meter declares loss of signal. Range 4 to 2^32-1.

- `clk`  input  1  system clock (100 MHz); the only clock.
- `resetn`  input  1  asynchronous, active-low reset.
- `sig_in`  input  1  measured signal, asynchronous to `clk`.
- `period`  output  32  `clk` cycles between the last two rising edges.
- `high_time`  output  32  `clk` cycles `sig_in` was high within that period.
- `n_est`  output  5  `max(msb_index(period) - 1, 0)`; equals n for a wave of period 2^(n+1).
- `pow2`  output  1  `period` is an exact power of two.
- `valid`  output  1  one-cycle pulse when the measurement outputs update.
- `locked`  output  1  at least one measurement completed since reset or timeout.
- `timeout`  output  1  sticky loss-of-signal flag.

## Operation
- Input path: `SYNC_STAGES`-deep flop chain produces `sig_s`, then one delay flop produces `sig_d`. `rise = sig_s & ~sig_d`. All of these flops reset to 0.
- Internal counters:
  - `cnt` (32-bit) counts cycles since the last rise.
  - `hcnt` (32-bit) counts high cycles since the last rise.
- ARM: entered from reset and from timeout. Waits until `sig_s == 0`, then goes to WAIT_EDGE. This prevents a high input at reset release from counting as an edge.
- WAIT_EDGE: on `rise`, sets `cnt <= 1`, sets `hcnt <= 1`, and goes to MEASURE. No `valid` is produced.
- MEASURE, cycle with `rise`:
  - `period <= cnt`, `high_time <= hcnt`.
  - `n_est` and `pow2` are computed from `cnt`.
  - `valid <= 1`, `locked <= 1`, `timeout <= 0`.
  - Then `cnt <= 1`, `hcnt <= 1`.
- MEASURE, cycle without `rise`:
  - `cnt <= cnt + 1`.
  - `hcnt <= hcnt + sig_s`.
- Timeout: in MEASURE or WAIT_EDGE, when `cnt == TIMEOUT_CYCLES` and there is no `rise` that cycle:
  - `timeout <= 1`, `locked <= 0`.
  - `period`, `high_time`, `n_est` and `pow2` are cleared to 0.
  - Go to ARM.
- Timeout counter in WAIT_EDGE: `cnt` is cleared on entry to WAIT_EDGE and counts there too.
- Simultaneous events: `rise` in the same cycle that `cnt` reaches `TIMEOUT_CYCLES` is a normal measurement; the timeout is not taken.
- Arithmetic: `cnt` never exceeds `TIMEOUT_CYCLES`, so it cannot wrap. `n_est` is combinational from `cnt` and registered with `period`. `n_est = 0` when `period < 4`.
- Minimum period is 2 (`sig_in` toggling every `clk` cycle). Faster inputs are out of specification; the result is undefined but the block must not lock up.

## Timing
- Reset (asynchronous):
  - `period`, `high_time`, `n_est`, `pow2`, `valid`, `locked`, `timeout` are all 0.
  - FSM is in ARM; synchronizer, `cnt` and `hcnt` are 0.
  - Asserting reset mid-measurement discards the measurement in progress.
- Latency: a `sig_in` rise first captured by synchronizer stage 1 at edge k gives `rise` high during cycle k+`SYNC_STAGES`. Outputs and `valid` are registered at the next edge, so `valid` is high in cycle k+`SYNC_STAGES`+1.
- `valid` is exactly one cycle wide. Outputs hold their value between pulses.
- The first `valid` after reset or timeout requires two rising edges after a low level has been seen.

## Test plan
1. Input toggles every 8 cycles (divider n=3) → second and later rises give `valid` pulses with `period=16`, `high_time=8`, `n_est=3`, `pow2=1`, `locked=1`.
2. Input toggles every cycle → `period=2`, `high_time=1`, `n_est=0`, `pow2=1`, with a `valid` pulse every 2 cycles.
3. Input high 3 cycles, low 7 cycles → `period=10`, `high_time=3`, `n_est=2`, `pow2=0`.
4. `TIMEOUT_CYCLES=1000`, stable lock, then input held constant → `timeout=1`, `locked=0`, `period=0` exactly 1000 cycles after the last `cnt` reload. Toggling resumed → no `valid` on the first rise; the second rise gives `valid=1` and `timeout=0`.
5. Input held high through reset release, then 16-cycle square wave → no `valid` until the input has gone low and two rises have followed; the first measurement is `period=16`.
6. `resetn` pulsed low between two rises while locked → all outputs are 0 in the same cycle; re-lock follows the sequence in scenario 5.
